// File: rtl/branch_predict_unit_pkg.sv
// Shared constants and types for the branch predict unit: func3 branch codes,
// counter reset pattern and the ALU flag bundle.
package branch_predict_unit_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Weakly-not-taken for the default 2-bit counter; ctr_weak_nt() generalises it.
    localparam logic [1:0] CTR_WEAK_NT = 2'b01;

    function automatic logic [3:0] ctr_weak_nt(input int bits);
        return 4'((1 << (bits - 1)) - 1);
    endfunction

    typedef struct packed {
        logic cf;
        logic zf;
        logic vf;
        logic sf;
    } alu_flags_t;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-side lookup and EX-side resolve/train signals of the branch predict unit.
interface branch_predict_unit_if #(
    parameter int PC_WIDTH   = 32,
    parameter int IDX_BITS   = 6,
    parameter int STAT_WIDTH = 16
);
    logic [PC_WIDTH-1:0]   if_pc;
    logic                  pred_taken;
    logic [IDX_BITS-1:0]   pred_idx;
    logic                  ex_valid;
    logic                  ex_is_branch;
    logic                  ex_is_jalr;
    logic [2:0]            ex_func3;
    logic                  cf;
    logic                  zf;
    logic                  vf;
    logic                  sf;
    logic [IDX_BITS-1:0]   ex_idx;
    logic                  ex_pred_taken;
    logic                  ex_taken;
    logic                  mispredict;
    logic [STAT_WIDTH-1:0] branch_count;
    logic [STAT_WIDTH-1:0] mispredict_count;

    modport master (
        output if_pc, ex_valid, ex_is_branch, ex_is_jalr, ex_func3,
               cf, zf, vf, sf, ex_idx, ex_pred_taken,
        input  pred_taken, pred_idx, ex_taken, mispredict,
               branch_count, mispredict_count
    );

    modport slave (
        input  if_pc, ex_valid, ex_is_branch, ex_is_jalr, ex_func3,
               cf, zf, vf, sf, ex_idx, ex_pred_taken,
        output pred_taken, pred_idx, ex_taken, mispredict,
               branch_count, mispredict_count
    );

endinterface

// File: rtl/branch_predict_unit_branch_resolve.sv
// Combinational branch outcome from func3 and the rs1 - rs2 subtract flags.
// cf = 1 means no borrow, so unsigned rs1 >= rs2.
module branch_resolve
    import branch_predict_unit_pkg::*;
(
    input  logic       valid,
    input  logic       is_jalr,
    input  logic [2:0] func3,
    input  alu_flags_t flags,
    output logic       taken
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        case (func3)
            BR_BEQ:  cond = flags.zf;
            BR_BNE:  cond = ~flags.zf;
            BR_BLT:  cond = flags.sf != flags.vf;
            BR_BGE:  cond = flags.sf == flags.vf;
            BR_BLTU: cond = ~flags.cf;
            BR_BGEU: cond = flags.cf;
            default: cond = 1'b0;
        endcase
    end

    assign taken = valid & (is_jalr | cond);

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: saturating-counter table looked up in IF, trained in EX,
// plus resolve, mispredict flag and saturating stats. Optional gshare via BRANCH_PREDICT_GSHARE_EN.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter  int PC_WIDTH   = 32,
    parameter  int ENTRIES    = 64,
    parameter  int CTR_BITS   = 2,
    parameter  int STAT_WIDTH = 16,
    localparam int IDX_BITS   = $clog2(ENTRIES)
) (
    input logic                  clk,
    input logic                  rst_n,
    branch_predict_unit_if.slave bus
);

    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic [ENTRIES-1:0][CTR_BITS-1:0] tbl_q, tbl_d;
    logic [STAT_WIDTH-1:0]            bc_q, bc_d;
    logic [STAT_WIDTH-1:0]            mc_q, mc_d;
    logic [IDX_BITS-1:0]              pc_idx, lookup_idx;
    logic [CTR_BITS-1:0]              cur_ctr;
    logic                             upd_en;
    logic                             taken;
    logic                             misp;
    alu_flags_t                       flags;

    assign pc_idx = bus.if_pc[IDX_BITS+1:2];
    assign flags  = '{cf: bus.cf, zf: bus.zf, vf: bus.vf, sf: bus.sf};

`ifdef BRANCH_PREDICT_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_q, ghr_d;

    assign lookup_idx = pc_idx ^ ghr_q;

    // History is speculative-free: shifted only at the EX update, never repaired.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_en) ghr_d = {ghr_q[IDX_BITS-2:0], taken};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ghr_q <= '0;
        else        ghr_q <= ghr_d;
    end
`else
    assign lookup_idx = pc_idx;
`endif

    // Read-before-write: lookup always sees the registered table, no bypass.
    assign bus.pred_taken = tbl_q[lookup_idx][CTR_BITS-1];
    assign bus.pred_idx   = lookup_idx;

    branch_resolve u_resolve (
        .valid   (bus.ex_valid),
        .is_jalr (bus.ex_is_jalr),
        .func3   (bus.ex_func3),
        .flags   (flags),
        .taken   (taken)
    );

    assign upd_en         = bus.ex_valid & bus.ex_is_branch;
    assign misp           = bus.ex_valid & (bus.ex_is_branch | bus.ex_is_jalr)
                          & (taken != bus.ex_pred_taken);
    assign bus.ex_taken   = taken;
    assign bus.mispredict = misp;

    assign cur_ctr = tbl_q[bus.ex_idx];

    always_comb begin
        tbl_d = tbl_q;
        if (upd_en) begin
            if (taken && cur_ctr != CTR_MAX)
                tbl_d[bus.ex_idx] = cur_ctr + CTR_BITS'(1);
            else if (!taken && cur_ctr != '0)
                tbl_d[bus.ex_idx] = cur_ctr - CTR_BITS'(1);
        end
    end

    always_comb begin
        bc_d = bc_q;
        mc_d = mc_q;
        if (upd_en && bc_q != '1) bc_d = bc_q + STAT_WIDTH'(1);
        if (misp && mc_q != '1)   mc_d = mc_q + STAT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tbl_q <= {ENTRIES{CTR_RST}};
            bc_q  <= '0;
            mc_q  <= '0;
        end else begin
            tbl_q <= tbl_d;
            bc_q  <= bc_d;
            mc_q  <= mc_d;
        end
    end

    assign bus.branch_count     = bc_q;
    assign bus.mispredict_count = mc_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a queue scoreboard; works with or
// without BRANCH_PREDICT_GSHARE_EN (history tracked in m_ghr).
module tb_branch_predict_unit;
    import branch_predict_unit_pkg::*;

    localparam int PCW  = 32;
    localparam int ENT  = 64;
    localparam int IDXB = 6;
    localparam int SW   = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.PC_WIDTH(PCW), .IDX_BITS(IDXB), .STAT_WIDTH(SW)) bif ();

    branch_predict_unit #(.PC_WIDTH(PCW), .ENTRIES(ENT), .CTR_BITS(2), .STAT_WIDTH(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t            sb[$];
    int              errors = 0;
    int              checks = 0;
    logic [IDXB-1:0] m_ghr  = '0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty observed=%0h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    function automatic logic [31:0] pc_for(input logic [IDXB-1:0] idx);
        return {24'b0, idx ^ m_ghr, 2'b00};
    endfunction

    task automatic drive_ex(input logic v, input logic br, input logic jr, input logic [2:0] f3,
                            input logic c, input logic z, input logic o, input logic s,
                            input logic [IDXB-1:0] idx, input logic pt);
        bif.ex_valid      = v;
        bif.ex_is_branch  = br;
        bif.ex_is_jalr    = jr;
        bif.ex_func3      = f3;
        bif.cf            = c;
        bif.zf            = z;
        bif.vf            = o;
        bif.sf            = s;
        bif.ex_idx        = idx;
        bif.ex_pred_taken = pt;
    endtask

    task automatic idle();
        drive_ex(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Advance one clock; when the edge trained the table, shift the model history.
    task automatic step(input logic upd, input logic tk);
        @(posedge clk);
        #1;
`ifdef BRANCH_PREDICT_GSHARE_EN
        if (upd) m_ghr = {m_ghr[IDXB-2:0], tk};
`else
        if (upd && tk) m_ghr = m_ghr;
`endif
    endtask

    task automatic look(input logic [31:0] pc, input logic [IDXB-1:0] eidx, input logic ept,
                        input string tag);
        bif.if_pc = pc;
        push({tag, "_idx"}, 32'(eidx));
        push({tag, "_pred"}, 32'(ept));
        #1;
        check(32'(bif.pred_idx));
        check(32'(bif.pred_taken));
    endtask

    task automatic chk_ex(input logic et, input logic em, input string tag);
        push({tag, "_taken"}, 32'(et));
        push({tag, "_misp"}, 32'(em));
        #1;
        check(32'(bif.ex_taken));
        check(32'(bif.mispredict));
    endtask

    task automatic chk_stats(input logic [SW-1:0] ebc, input logic [SW-1:0] emc, input string tag);
        push({tag, "_bc"}, 32'(ebc));
        push({tag, "_mc"}, 32'(emc));
        check(32'(bif.branch_count));
        check(32'(bif.mispredict_count));
    endtask

    task automatic resolve(input logic [2:0] f3, input logic c, input logic z, input logic o,
                           input logic s, input logic et, input string tag);
        drive_ex(1'b1, 1'b0, 1'b0, f3, c, z, o, s, 6'd20, 1'b0);
        chk_ex(et, 1'b0, tag);
    endtask

    initial begin
        idle();
        bif.if_pc = '0;
        #12;
        chk_stats(4'd0, 4'd0, "reset");
        rst_n = 1'b1;
        step(1'b0, 1'b0);

        look(32'h0,  6'd0,  1'b0, "lk_0x0");
        look(32'h4,  6'd1,  1'b0, "lk_0x4");
        look(32'hFC, 6'd63, 1'b0, "lk_0xfc");

        // Train idx 5 taken three times: 01 -> 10 -> 11 -> 11.
        look(pc_for(6'd5), 6'd5, 1'b0, "pre_train");
        for (int i = 0; i < 3; i++) begin
            drive_ex(1'b1, 1'b1, 1'b0, BR_BEQ, 1'b0, 1'b1, 1'b0, 1'b0, 6'd5, 1'b1);
            chk_ex(1'b1, 1'b0, "beq_t");
            step(1'b1, 1'b1);
            look(pc_for(6'd5), 6'd5, 1'b1, "train_t");
        end
        chk_stats(4'd3, 4'd0, "after_3t");

        // Two not-taken: 11 -> 10 (still taken) -> 01 (not taken); shows saturation held at 11.
        drive_ex(1'b1, 1'b1, 1'b0, BR_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5, 1'b0);
        chk_ex(1'b0, 1'b0, "beq_nt");
        step(1'b1, 1'b0);
        look(pc_for(6'd5), 6'd5, 1'b1, "nt1");
        step(1'b1, 1'b0);
        look(pc_for(6'd5), 6'd5, 1'b0, "nt2");
        chk_stats(4'd5, 4'd0, "after_nt");

        resolve(BR_BLT,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "blt");
        resolve(BR_BGEU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "bgeu");
        resolve(3'b010,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "f3_010");
        resolve(BR_BNE,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "bne");
        resolve(BR_BLTU, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "bltu");
        resolve(BR_BGE,  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "bge");

        drive_ex(1'b0, 1'b1, 1'b0, BR_BEQ, 1'b0, 1'b1, 1'b0, 1'b0, 6'd5, 1'b1);
        chk_ex(1'b0, 1'b0, "invalid");
        step(1'b0, 1'b0);
        chk_stats(4'd5, 4'd0, "invalid_noupd");

        drive_ex(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 6'd5, 1'b0);
        chk_ex(1'b1, 1'b1, "jalr");
        step(1'b0, 1'b1);
        idle();
        chk_stats(4'd5, 4'd1, "jalr_stats");
        look(pc_for(6'd5), 6'd5, 1'b0, "jalr_noupd");

        // Same-cycle lookup/update of idx 7: old value now, trained value next cycle.
        drive_ex(1'b1, 1'b1, 1'b0, BR_BEQ, 1'b0, 1'b1, 1'b0, 1'b0, 6'd7, 1'b1);
        look(pc_for(6'd7), 6'd7, 1'b0, "rbw_same");
        step(1'b1, 1'b1);
        idle();
        look(pc_for(6'd7), 6'd7, 1'b1, "rbw_next");
        chk_stats(4'd6, 4'd1, "rbw_stats");

        for (int i = 0; i < 20; i++) begin
            drive_ex(1'b1, 1'b1, 1'b0, BR_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 6'd10, 1'b1);
            if (i == 0) chk_ex(1'b0, 1'b1, "sat_misp");
            step(1'b1, 1'b0);
        end
        idle();
        chk_stats(4'd15, 4'd15, "saturate");

        // Asynchronous reset in the middle of a clock phase.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        m_ghr = '0;
        chk_stats(4'd0, 4'd0, "async_rst");
        look(32'h1C, 6'd7, 1'b0, "rst_tbl");
        drive_ex(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
        chk_ex(1'b1, 1'b1, "rst_comb");
        idle();
        #10;
        rst_n = 1'b1;
        #10;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Next-generation branch decision block. It combines the resolve logic (func3 plus ALU flags giving taken/not-taken) with a parametrised table of saturating counters that predicts in IF and trains in EX.
- Lookup sits beside the IF stage. Resolve/update sits in EX and drives the redirect/flush request.
- Also keeps saturating performance counters for resolved branches and mispredicts.

Parameters:
- PC_WIDTH, 32, width of PC inputs.
- ENTRIES, 64, number of prediction counters; must be a power of two and at least 4.
- IDX_BITS, $clog2(ENTRIES), table index width; derived, not overridden.
- CTR_BITS, 2, saturating-counter width; 1 to 4 allowed.
- STAT_WIDTH, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  PC_WIDTH  fetch PC to predict
- pred_taken  out  1  prediction for if_pc; combinational
- pred_idx  out  IDX_BITS  table index used for if_pc; carried down the pipeline
- ex_valid  in  1  EX holds a live (non-bubble, non-flushed) instruction
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_is_jalr  in  1  EX instruction is JALR
- ex_func3  in  3  branch func3
- cf, zf, vf, sf  in  1 each  ALU flags from the rs1 - rs2 subtract
- ex_idx  in  IDX_BITS  pred_idx captured at fetch
- ex_pred_taken  in  1  pred_taken captured at fetch
- ex_taken  out  1  resolved outcome; combinational
- mispredict  out  1  EX outcome disagrees with prediction; combinational
- branch_count  out  STAT_WIDTH  resolved conditional branches; registered
- mispredict_count  out  STAT_WIDTH  mispredicts; registered

Behaviour:
- Resolve, combinational, evaluated only when ex_valid is 1; otherwise ex_taken = 0:
  - BEQ (000): zf
  - BNE (001): ~zf
  - BLT (100): sf != vf
  - BGE (101): sf == vf
  - BLTU (110): ~cf
  - BGEU (111): cf
  - 010 and 011: 0
  - cf = 1 means no borrow.
  - ex_is_jalr forces ex_taken = 1 regardless of func3.
- mispredict = ex_valid & (ex_is_branch | ex_is_jalr) & (ex_taken != ex_pred_taken). Zero otherwise.
- Table: ENTRIES counters, each CTR_BITS wide.
  - Prediction is the counter's MSB.
  - Reset value of every counter is weakly-not-taken: MSB = 0, all other bits = 1 (for 2 bits this is 01).
- Lookup index: if_pc[IDX_BITS+1:2] (word aligned). pred_idx outputs this index.
- Update happens at the rising edge when ex_valid & ex_is_branch:
  - taken: counter[ex_idx] increments, saturating at all-ones.
  - not taken: counter[ex_idx] decrements, saturating at zero.
  - JALR and non-branches never update.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value (read-before-write, no bypass).
- Statistics, both saturating at all-ones, never wrapping:
  - branch_count increments on every update cycle.
  - mispredict_count increments on every cycle with mispredict = 1.
- Reset (asserted asynchronously, at any time, including mid-update):
  - all counters return to their reset value,
  - both statistics counters = 0,
  - GHR = 0 (if present).
  - Combinational outputs follow the inputs.
- Latency:
  - prediction: 0 cycles.
  - training: visible to a lookup in the cycle after the update edge.

Optional Feature:
- Macro: BRANCH_PREDICT_GSHARE_EN.
- Defined:
  - Add an internal global history register (GHR), IDX_BITS wide.
  - Lookup index = if_pc[IDX_BITS+1:2] XOR GHR.
  - On each update edge, GHR <= {GHR[IDX_BITS-2:0], ex_taken}.
  - A mispredict does not repair the GHR.
- Undefined: no GHR; the index is the PC slice only.
- Ports are identical in both builds. ex_idx is always the trained index.

Decomposition:
- Shared defines file gains:
  - the existing BR_* func3 codes (reused, not redefined),
  - a CTR_WEAK_NT constant pattern.
- Natural sub-module: branch_resolve, the combinational func3/flag decode producing ex_taken. It is instantiated once.
- The table, the GHR and the statistics counters stay in the top module.

Test Plan:
- Reset then lookups of if_pc = 0x0, 0x4, 0xFC -> pred_taken = 0. pred_idx = 0, 1, 63.
- Three taken BEQ updates (zf = 1) at ex_idx 5:
  - counter 01 -> 10 -> 11 -> 11 (saturates).
  - Lookup of PC 0x14 gives pred_taken = 1 from the cycle after the first update.
  - branch_count = 3.
- Resolve sweep, func3 × flags:
  - BLT with sf = 1, vf = 0 -> taken.
  - BGEU with cf = 0 -> not taken.
  - func3 = 010 -> not taken.
  - ex_valid = 0 -> ex_taken = 0, mispredict = 0, no update.
- JALR with ex_pred_taken = 0 -> ex_taken = 1, mispredict = 1, mispredict_count += 1, table unchanged.
- Same-cycle lookup and update on idx 7 (counter 01, taken) -> pred_taken = 0 that cycle, 1 the next.
- Counter saturation:
  - Force STAT_WIDTH = 4.
  - Run 20 mispredicted branches -> both counters hold at 15.
  - Assert rst_n low mid-clock-phase -> all outputs clear immediately.
  - With GSHARE_EN: GHR = 0, and idx = PC slice after reset.
